// File: rtl/atp_pkg.sv
// atp_pkg: state/method codes and receipt frame helpers for the ATP printer link.
// Build macro ATP_TX_PARITY_EN selects 8E1 framing instead of 8N1.
package atp_pkg;

  typedef enum logic [3:0] {
    S_SCANQR  = 4'h0,
    S_DISP    = 4'h1,
    S_PAYSEL  = 4'h2,
    S_PAYBAL  = 4'h3,
    S_ONLINE  = 4'h4,
    S_OFFLINE = 4'h5,
    S_CARDUPI = 4'h6,
    S_CASH    = 4'h7,
    S_DDCHQ   = 4'h8,
    S_FAIL    = 4'h9,
    S_SUCC    = 4'hA,
    S_PRINT   = 4'hB
  } atp_state_e;

  localparam logic [7:0] M_NONE    = 8'h00;
  localparam logic [7:0] M_BAL     = 8'h01;
  localparam logic [7:0] M_CARDUPI = 8'h02;
  localparam logic [7:0] M_CASH    = 8'h03;
  localparam logic [7:0] M_DDCHQ   = 8'h04;

  localparam logic [7:0] RCPT_HDR = 8'hA5;
  localparam int         RCPT_LEN = 7;

`ifdef ATP_TX_PARITY_EN
  localparam int UART_BITS = 11;
`else
  localparam int UART_BITS = 10;
`endif

  // Byte idx of the receipt; index 6 is the XOR of bytes 1..5.
  function automatic logic [7:0] rcpt_byte(
    input logic [2:0]  idx,
    input logic [7:0]  id,
    input logic [7:0]  meth,
    input logic [15:0] amt,
    input logic [3:0]  fc
  );
    logic [7:0] b5;
    b5 = {4'h0, fc};
    case (idx)
      3'd0:    rcpt_byte = RCPT_HDR;
      3'd1:    rcpt_byte = id;
      3'd2:    rcpt_byte = meth;
      3'd3:    rcpt_byte = amt[15:8];
      3'd4:    rcpt_byte = amt[7:0];
      3'd5:    rcpt_byte = b5;
      default: rcpt_byte = id ^ meth ^ amt[15:8] ^ amt[7:0] ^ b5;
    endcase
  endfunction

endpackage

// File: rtl/atp_uart_tx.sv
// atp_uart_tx: LSB-first UART byte serialiser with valid/ready intake.
// ATP_TX_PARITY_EN inserts an even-parity bit after bit 7.
module atp_uart_tx
  import atp_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_valid,
  input  logic [7:0] i_data,
  output logic       o_ready,
  output logic       o_last,
  output logic       o_tx
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int SW = UART_BITS - 1;
  localparam logic [CW-1:0] C_MAX = CW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]    B_LAST = 4'(UART_BITS - 1);

  logic          r_busy;
  logic [CW-1:0] r_cnt;
  logic [3:0]    r_bit;
  logic [SW-1:0] r_sh;
  logic          r_tx;
  logic [SW-1:0] w_load;
  logic          w_last;

`ifdef ATP_TX_PARITY_EN
  assign w_load = {1'b1, ^i_data, i_data};
`else
  assign w_load = {1'b1, i_data};
`endif

  // Last cycle of the stop bit: a new byte may be taken with no gap.
  assign w_last  = r_busy && (r_cnt == C_MAX) && (r_bit == B_LAST);
  assign o_last  = w_last;
  assign o_ready = !r_busy || w_last;
  assign o_tx    = r_tx;

  // Baud counter and shift register; start bit is driven on the load edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
      r_bit  <= '0;
      r_sh   <= '1;
      r_tx   <= 1'b1;
    end else if (i_valid && o_ready) begin
      r_busy <= 1'b1;
      r_cnt  <= '0;
      r_bit  <= '0;
      r_sh   <= w_load;
      r_tx   <= 1'b0;
    end else if (r_busy) begin
      if (r_cnt == C_MAX) begin
        r_cnt <= '0;
        if (r_bit == B_LAST) begin
          r_busy <= 1'b0;
          r_tx   <= 1'b1;
        end else begin
          r_bit <= r_bit + 4'd1;
          r_tx  <= r_sh[0];
          r_sh  <= {1'b1, r_sh[SW-1:1]};
        end
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/atp_receipt_tx.sv
// atp_receipt_tx: tracks the payment path and prints a 7-byte receipt frame.
// ATP_TX_PARITY_EN selects 8E1 bytes (77 bit-times) instead of 8N1 (70).
module atp_receipt_tx
  import atp_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int AMT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       state_in,
  input  logic [AMT_W-1:0] amount,
  input  logic             amount_vld,
  output logic             tx,
  output logic             busy,
  output logic             done,
  output logic [7:0]       txn_id,
  output logic             err_nosucc,
  output logic             overrun
);

  logic [3:0]       r_prev;
  logic [AMT_W-1:0] r_amt;
  logic [7:0]       r_meth;
  logic [3:0]       r_fail;
  logic             r_succ;

  logic             r_busy;
  logic             r_done;
  logic             r_err;
  logic             r_ovr;
  logic [7:0]       r_txn;
  logic [2:0]       r_idx;
  logic [7:0]       r_s_id;
  logic [7:0]       r_s_meth;
  logic [AMT_W-1:0] r_s_amt;
  logic [3:0]       r_s_fail;

  logic       w_ent;
  logic       w_print;
  logic       w_valid;
  logic       w_ready;
  logic       w_last;
  logic       w_fin;
  logic [7:0] w_byte;

  assign w_ent   = (state_in != r_prev);
  assign w_print = w_ent && (state_in == S_PRINT);
  assign w_valid = r_busy && (r_idx != 3'(RCPT_LEN));
  assign w_fin   = r_busy && (r_idx == 3'(RCPT_LEN)) && w_last;
  assign w_byte  = rcpt_byte(r_idx, r_s_id, r_s_meth,
                             r_s_amt, r_s_fail);

  assign busy       = r_busy;
  assign done       = r_done;
  assign txn_id     = r_txn;
  assign err_nosucc = r_err;
  assign overrun    = r_ovr;

  // Payment record: updated on state entries and DISP amount strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev <= S_SCANQR;
      r_amt  <= '0;
      r_meth <= M_NONE;
      r_fail <= '0;
      r_succ <= 1'b0;
    end else begin
      r_prev <= state_in;
      if (amount_vld && state_in == S_DISP)
        r_amt <= amount;
      if (w_ent) begin
        case (state_in)
          S_SCANQR: begin
            r_amt  <= '0;
            r_meth <= M_NONE;
            r_fail <= '0;
            r_succ <= 1'b0;
          end
          S_PAYBAL:  r_meth <= M_BAL;
          S_CARDUPI: r_meth <= M_CARDUPI;
          S_CASH:    r_meth <= M_CASH;
          S_DDCHQ:   r_meth <= M_DDCHQ;
          S_FAIL:
            if (r_fail != 4'hF)
              r_fail <= r_fail + 4'd1;
          S_SUCC:    r_succ <= 1'b1;
          default: ;
        endcase
      end
    end
  end

  // PRINT entry handling, frame snapshot and byte sequencing.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_ovr    <= 1'b0;
      r_txn    <= '0;
      r_idx    <= '0;
      r_s_id   <= '0;
      r_s_meth <= '0;
      r_s_amt  <= '0;
      r_s_fail <= '0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      if (w_print) begin
        if (r_busy) begin
          r_ovr <= 1'b1;
        end else if (!r_succ) begin
          r_err <= 1'b1;
        end else begin
          r_busy   <= 1'b1;
          r_idx    <= '0;
          r_s_id   <= r_txn;
          r_s_meth <= r_meth;
          r_s_amt  <= r_amt;
          r_s_fail <= r_fail;
        end
      end
      if (w_valid && w_ready)
        r_idx <= r_idx + 3'd1;
      if (w_fin) begin
        r_busy <= 1'b0;
        r_done <= 1'b1;
        r_txn  <= r_txn + 8'd1;
      end
    end
  end

  atp_uart_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart (
    .clk    (clk),
    .rst    (rst),
    .i_valid(w_valid),
    .i_data (w_byte),
    .o_ready(w_ready),
    .o_last (w_last),
    .o_tx   (tx)
  );

endmodule
